ucie_flit_tx_arbiter: RTL

Shares the single D2D adapter transmit flit path between NUM_REQ protocol-layer stacks (PCIe, CXL.io/cache/mem, streaming, management). It is credit-gated per requester, round-robin fair, and holds a grant for the full multi-beat flit. It also blocks new flits whenever the RDI is not in RDI_ACTIVE. It sits between the protocol-layer TX FIFOs and the flit packer/CRC stage; RDI state and flit-format types come from ucie_pkg.

---
 rtl/ucie_flit_tx_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ucie_flit_tx_arbiter.sv
// Purpose: round-robin, credit-gated arbiter sharing the D2D adapter TX flit path between protocol stacks.
// Latency: grant decided in IDLE, first beat visible the next cycle; beats then pass combinationally from owner to tx_*.
// Backpressure: tx_ready_i=0 stalls the owner indefinitely; grant is held for the whole flit, non-owners see ready=0.

package ucie_pkg;

    // Raw Die-to-Die Interface state as seen by the adapter.
    typedef enum logic [3:0] {
        RDI_RESET     = 4'h0,
        RDI_ACTIVE    = 4'h1,
        RDI_PM_NAK    = 4'h3,
        RDI_PM_ENTRY  = 4'h4,
        RDI_L1        = 4'h5,
        RDI_L2        = 4'h8,
        RDI_LINKRESET = 4'h9,
        RDI_LINKERROR = 4'hA,
        RDI_RETRAIN   = 4'hB,
        RDI_DISABLED  = 4'hC
    } rdi_state_t;

    // Protocol tag carried alongside every beat.
    typedef enum logic [3:0] {
        PROTO_PCIE      = 4'h0,
        PROTO_CXL_IO    = 4'h1,
        PROTO_CXL_CACHE = 4'h2,
        PROTO_CXL_MEM   = 4'h3,
        PROTO_STREAM    = 4'h4,
        PROTO_MGMT      = 4'h5
    } protocol_type_t;

endpackage : ucie_pkg

module ucie_flit_tx_arbiter
    import ucie_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 256,
    parameter int CREDIT_W  = 8,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    rdi_state_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*4-1:0]          req_protocol_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_valid_o,
    output logic [DATA_W-1:0]             tx_data_o,
    output logic                          tx_last_o,
    output logic [3:0]                    tx_protocol_o,
    output logic [REQ_IDX_W-1:0]          tx_src_o,
    input  logic                          tx_ready_i,
    input  logic [NUM_REQ-1:0]            credit_return_i,
    input  logic                          credit_load_i,
    input  logic [CREDIT_W-1:0]           credit_init_i,
    output logic [NUM_REQ*CREDIT_W-1:0]   credit_cnt_o,
    output logic                          busy_o,
    output logic                          pm_blocked_o,
    output logic                          err_credit_ovf_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    state_t                              state_q, state_d;
    logic [REQ_IDX_W-1:0]                owner_q, owner_d;
    logic [REQ_IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][CREDIT_W-1:0]    credit_q, credit_d;
    logic                                err_ovf_q, err_ovf_d;

    // Per-requester views of the flattened input buses.
    logic [NUM_REQ-1:0][DATA_W-1:0]      data_v;
    logic [NUM_REQ-1:0][3:0]             proto_v;

    logic                                rdi_active;
    logic [NUM_REQ-1:0]                  eligible;
    logic                                win_found;
    logic [REQ_IDX_W-1:0]                win_idx;
    logic                                grant;
    logic [NUM_REQ-1:0]                  consume;

    assign data_v     = req_data_i;
    assign proto_v    = req_protocol_i;
    assign rdi_active = (rdi_state_i == RDI_ACTIVE);

    // A requester may compete only with a beat pending and at least one flit credit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (credit_q[i] != '0);
        end
    end

    // Round-robin search: first eligible index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = REQ_IDX_W'(idx);
            end
        end
    end

    // FSM next-state and all flit-path outputs; outputs stay 0 in IDLE.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        grant         = 1'b0;
        tx_valid_o    = 1'b0;
        tx_data_o     = '0;
        tx_last_o     = 1'b0;
        tx_protocol_o = '0;
        tx_src_o      = '0;
        req_ready_o   = '0;
        busy_o        = 1'b0;
        pm_blocked_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Someone could go, but the link is not in a state to take flits.
                pm_blocked_o = (|eligible) && !rdi_active;
                if (rdi_active && win_found) begin
                    grant    = 1'b1;
                    owner_d  = win_idx;
                    rr_ptr_d = REQ_IDX_W'((int'(win_idx) + 1) % NUM_REQ);
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                // The flit always runs to completion, even if the RDI leaves ACTIVE.
                busy_o               = 1'b1;
                tx_valid_o           = req_valid_i[owner_q];
                tx_data_o            = data_v[owner_q];
                tx_last_o            = req_last_i[owner_q];
                tx_protocol_o        = proto_v[owner_q];
                tx_src_o             = owner_q;
                req_ready_o[owner_q] = tx_ready_i;
                if (tx_valid_o && tx_ready_i && tx_last_o) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Credit counter update: load beats everything, a simultaneous consume and return cancel,
    // a return at the top of the range saturates and raises the sticky overflow flag.
    always_comb begin
        credit_d  = credit_q;
        err_ovf_d = err_ovf_q;
        consume   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            consume[i] = grant && (win_idx == REQ_IDX_W'(i));
        end
        if (credit_load_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                credit_d[i] = credit_init_i;
            end
            err_ovf_d = 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (consume[i] && credit_return_i[i]) begin
                    credit_d[i] = credit_q[i];
                end else if (credit_return_i[i]) begin
                    if (credit_q[i] == CREDIT_MAX) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        credit_d[i] = credit_q[i] + CREDIT_W'(1);
                    end
                end else if (consume[i]) begin
                    credit_d[i] = credit_q[i] - CREDIT_W'(1);
                end
            end
        end
    end

    // Credit counters and overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q  <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign credit_cnt_o     = credit_q;
    assign err_credit_ovf_o = err_ovf_q;

endmodule : ucie_flit_tx_arbiter
